// File: rtl/st7735_spi_sequencer.sv
// ST7735 panel front end: power-on reset sequencing, then SPI mode-0 bytes and ms delays
// handed in through a valid/ready request port.
module st7735_spi_sequencer #(
    parameter int unsigned CLOCK_SPEED_MHZ = 12,
    parameter int unsigned SCLK_DIV        = 2,
    parameter int unsigned RESET_PULSE_US  = 10,
    parameter int unsigned RESET_WAIT_MS   = 120
) (
    input  logic       SYSTEM_CLK,
    input  logic       SYSTEM_RESET,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       TX_DELAY,
    input  logic       TX_DC,
    input  logic [7:0] TX_DATA,
    input  logic       TX_LAST,
    output logic       INIT_DONE,
    output logic       BUSY,
    output logic       CS,
    output logic       MOSI,
    output logic       DC,
    output logic       LCD_CLK,
    output logic       RESET
);

    localparam int unsigned PRE_W         = (CLOCK_SPEED_MHZ > 1) ? $clog2(CLOCK_SPEED_MHZ) : 1;
    localparam int unsigned US_W          = 10;
    localparam int unsigned PULSE_MS_PART = (RESET_PULSE_US - 1) / 1000;
    localparam int unsigned MS_BIG        = (RESET_WAIT_MS > PULSE_MS_PART) ? RESET_WAIT_MS : PULSE_MS_PART;
    localparam int unsigned MS_MAX        = (MS_BIG > 255) ? MS_BIG : 255;
    localparam int unsigned MS_W          = $clog2(MS_MAX + 1);
    localparam int unsigned DIV_W         = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(CLOCK_SPEED_MHZ - 1);
    localparam logic [US_W-1:0]  US_LAST       = US_W'(999);
    localparam logic [US_W-1:0]  PULSE_US_LAST = US_W'((RESET_PULSE_US - 1) % 1000);
    localparam logic [MS_W-1:0]  PULSE_MS_LAST = MS_W'(PULSE_MS_PART);
    localparam logic [MS_W-1:0]  WAIT_MS_LAST  = MS_W'(RESET_WAIT_MS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(SCLK_DIV - 1);
    localparam logic [3:0]       HALF_LAST     = 4'd15;

    typedef enum logic [2:0] {
        RST_ASSERT,
        RST_WAIT,
        IDLE,
        SHIFT,
        DELAY
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PRE_W-1:0] r_pre, w_pre_nxt;
    logic [US_W-1:0]  r_us, w_us_nxt;
    logic [MS_W-1:0]  r_ms, w_ms_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [3:0]       r_half, w_half_nxt;
    logic [6:0]       r_sh, w_sh_nxt;
    logic [7:0]       r_delay, w_delay_nxt;
    logic             r_last, w_last_nxt;
    logic             r_cs, w_cs_nxt;
    logic             r_mosi, w_mosi_nxt;
    logic             r_dc, w_dc_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_rst_n, w_rst_n_nxt;
    logic             r_init_done, w_init_done_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_busy;
    logic             w_tick_us;
    logic             w_tick_ms;
    logic             w_timed;

    assign w_tick_us = (r_pre == PRE_LAST);
    assign w_tick_ms = w_tick_us && (r_us == US_LAST);
    assign w_timed   = (r_state == RST_ASSERT) || (r_state == RST_WAIT) || (r_state == DELAY);

    // Next-state, timing counters and pin values
    always_comb begin
        w_state_nxt     = r_state;
        w_pre_nxt       = r_pre;
        w_us_nxt        = r_us;
        w_ms_nxt        = r_ms;
        w_div_nxt       = r_div;
        w_half_nxt      = r_half;
        w_sh_nxt        = r_sh;
        w_delay_nxt     = r_delay;
        w_last_nxt      = r_last;
        w_cs_nxt        = r_cs;
        w_mosi_nxt      = r_mosi;
        w_dc_nxt        = r_dc;
        w_sclk_nxt      = r_sclk;
        w_rst_n_nxt     = r_rst_n;
        w_init_done_nxt = r_init_done;

        if (w_timed) begin
            if (w_tick_us) begin
                w_pre_nxt = '0;
                if (r_us == US_LAST) begin
                    w_us_nxt = '0;
                    w_ms_nxt = r_ms + MS_W'(1);
                end else begin
                    w_us_nxt = r_us + US_W'(1);
                end
            end else begin
                w_pre_nxt = r_pre + PRE_W'(1);
            end
        end

        case (r_state)
            RST_ASSERT: begin
                w_rst_n_nxt = 1'b0;
                if (w_tick_us && (r_us == PULSE_US_LAST) && (r_ms == PULSE_MS_LAST)) begin
                    w_state_nxt = RST_WAIT;
                    w_rst_n_nxt = 1'b1;
                end
            end
            RST_WAIT: begin
                if (w_tick_ms && (r_ms == WAIT_MS_LAST)) begin
                    w_state_nxt     = IDLE;
                    w_init_done_nxt = 1'b1;
                end
            end
            IDLE: begin
                if (TX_VALID) begin
                    if (TX_DELAY) begin
                        w_state_nxt = DELAY;
                        w_cs_nxt    = 1'b1;
                        w_delay_nxt = TX_DATA;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_cs_nxt    = 1'b0;
                        w_dc_nxt    = TX_DC;
                        w_mosi_nxt  = TX_DATA[7];
                        w_sh_nxt    = TX_DATA[6:0];
                        w_last_nxt  = TX_LAST;
                        w_sclk_nxt  = 1'b0;
                        w_div_nxt   = '0;
                        w_half_nxt  = '0;
                    end
                end
            end
            SHIFT: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (r_div == DIV_LAST) begin
                    w_div_nxt  = '0;
                    w_sclk_nxt = ~r_sclk;
                    w_half_nxt = r_half + 4'd1;
                    if (r_half == HALF_LAST) begin
                        w_state_nxt = IDLE;
                        w_cs_nxt    = r_last;
                    end else if (r_sclk) begin
                        // falling edge: present the next bit for the following rise
                        w_mosi_nxt = r_sh[6];
                        w_sh_nxt   = {r_sh[5:0], 1'b0};
                    end
                end
            end
            DELAY: begin
                if ((r_delay == 8'd0) ||
                    (w_tick_ms && (r_ms == (MS_W'(r_delay) - MS_W'(1))))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = RST_ASSERT;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_pre_nxt = '0;
            w_us_nxt  = '0;
            w_ms_nxt  = '0;
        end

        w_ready_nxt = (w_state_nxt == IDLE);
    end

    // State register and registered outputs
    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            r_state     <= RST_ASSERT;
            r_pre       <= '0;
            r_us        <= '0;
            r_ms        <= '0;
            r_div       <= '0;
            r_half      <= '0;
            r_sh        <= '0;
            r_delay     <= '0;
            r_last      <= 1'b0;
            r_cs        <= 1'b1;
            r_mosi      <= 1'b0;
            r_dc        <= 1'b0;
            r_sclk      <= 1'b0;
            r_rst_n     <= 1'b0;
            r_init_done <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_pre       <= w_pre_nxt;
            r_us        <= w_us_nxt;
            r_ms        <= w_ms_nxt;
            r_div       <= w_div_nxt;
            r_half      <= w_half_nxt;
            r_sh        <= w_sh_nxt;
            r_delay     <= w_delay_nxt;
            r_last      <= w_last_nxt;
            r_cs        <= w_cs_nxt;
            r_mosi      <= w_mosi_nxt;
            r_dc        <= w_dc_nxt;
            r_sclk      <= w_sclk_nxt;
            r_rst_n     <= w_rst_n_nxt;
            r_init_done <= w_init_done_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= ~w_ready_nxt;
        end
    end

    assign TX_READY  = r_ready;
    assign BUSY      = r_busy;
    assign INIT_DONE = r_init_done;
    assign CS        = r_cs;
    assign MOSI      = r_mosi;
    assign DC        = r_dc;
    assign LCD_CLK   = r_sclk;
    assign RESET     = r_rst_n;

endmodule
